// File: rtl/vram_arb_pkg.sv
// ============================================================================
// vram_arb_pkg : shared constants, state encoding and helpers for
//                vram_fetch_arbiter.               Rev 1.0
// ============================================================================
`default_nettype none

package vram_arb_pkg;

   localparam int         NUM_REQ = 3;
   localparam logic [1:0] REQ_L0  = 2'd0;
   localparam logic [1:0] REQ_L1  = 2'd1;
   localparam logic [1:0] REQ_SPR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   // Requester index +1, wrapping after the sprite engine.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx >= REQ_SPR) ? REQ_L0 : idx + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_select.sv
// ============================================================================
// rr_priority_select : combinational pick of the first eligible requester,
//                      searching upward from a start pointer.   Rev 1.0
// ============================================================================
`default_nettype none

module rr_priority_select
   import vram_arb_pkg::*;
(
   input  logic [2:0] i_elig,
   input  logic [1:0] i_start,
   output logic       o_valid,
   output logic [1:0] o_idx
);

   logic [1:0] w_cand;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = REQ_L0;
      w_cand  = (i_start > REQ_SPR) ? REQ_L0 : i_start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_valid && i_elig[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
         w_cand = next_idx(w_cand);
      end
   end

endmodule

`default_nettype wire

// File: rtl/vram_fetch_arbiter.sv
// ============================================================================
// vram_fetch_arbiter : serialises layer0/layer1/sprite fetches onto the single
//                      VRAM read port. Define ARB_ROUND_ROBIN_EN for rotating
//                      priority, otherwise fixed 0 > 1 > 2.      Rev 1.0
// ============================================================================
`default_nettype none

module vram_fetch_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int RAM_LATENCY = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  line_start,
   input  logic                  sprites_enabled,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [2:0]            req_strobe,
   output logic [2:0]            req_ack,
   output logic [DATA_W-1:0]     rddata,
   output logic [ADDR_W-1:0]     vram_addr,
   output logic                  vram_rden,
   input  logic [DATA_W-1:0]     vram_rddata
);

   localparam int CNT_W = $clog2(RAM_LATENCY + 1);

   state_t            r_state;
   logic [1:0]        r_grant;
   logic [CNT_W-1:0]  r_wait_cnt;

   logic [2:0]        w_ack_mask;
   logic [2:0]        w_elig;
   logic [1:0]        w_start;
   logic              w_win_valid;
   logic [1:0]        w_win_idx;
   logic [ADDR_W-1:0] w_win_addr;
   logic              w_arb_state;
   logic              w_grant_now;

   // The requester being acked cannot win again in its own ack cycle.
   assign w_ack_mask  = (r_state == ST_ACK) ? ~onehot3(r_grant) : 3'b111;
   assign w_elig      = req_strobe & {sprites_enabled, 2'b11} & w_ack_mask;
   assign w_win_addr  = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
   assign w_arb_state = (r_state == ST_IDLE) || (r_state == ST_ACK);
   assign w_grant_now = w_arb_state && w_win_valid;

   rr_priority_select u_sel (
      .i_elig  (w_elig),
      .i_start (w_start),
      .o_valid (w_win_valid),
      .o_idx   (w_win_idx)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] r_rr_ptr;

   // line_start takes precedence over a coincident grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rr_ptr <= REQ_L0;
      else if (line_start)
         r_rr_ptr <= REQ_L0;
      else if (w_grant_now)
         r_rr_ptr <= next_idx(w_win_idx);
   end

   assign w_start = r_rr_ptr;
`else
   logic w_unused_line_start;
   assign w_unused_line_start = line_start;
   assign w_start             = REQ_L0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_grant    <= REQ_L0;
         r_wait_cnt <= '0;
         req_ack    <= '0;
         rddata     <= '0;
         vram_addr  <= '0;
         vram_rden  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACK: begin
               req_ack <= '0;
               if (w_win_valid) begin
                  vram_addr <= w_win_addr;
                  vram_rden <= 1'b1;
                  r_grant   <= w_win_idx;
                  r_state   <= ST_ISSUE;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               vram_rden  <= 1'b0;
               r_wait_cnt <= CNT_W'(RAM_LATENCY - 1);
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_wait_cnt == '0) begin
                  rddata  <= vram_rddata;
                  req_ack <= onehot3(r_grant);
                  r_state <= ST_ACK;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_fetch_arbiter.sv
// ============================================================================
// tb_vram_fetch_arbiter : directed self-checking bench, one L=1 instance and
//                         one L=3 instance. Honours ARB_ROUND_ROBIN_EN. Rev 1.0
// ============================================================================
`default_nettype none

module tb_vram_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        line_start;
   logic        spr_en;

   logic [47:0] addr_a;
   logic [2:0]  strobe_a;
   logic [2:0]  ack_a;
   logic [31:0] rddata_a;
   logic [15:0] vaddr_a;
   logic        rden_a;
   logic [31:0] vdata_a;

   logic [47:0] addr_b;
   logic [2:0]  strobe_b;
   logic [2:0]  ack_b;
   logic [31:0] rddata_b;
   logic [15:0] vaddr_b;
   logic        rden_b;
   logic [31:0] vdata_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vram_fetch_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LATENCY(1)) u_dut_a (
      .clk(clk), .rst(rst), .line_start(line_start), .sprites_enabled(spr_en),
      .req_addr(addr_a), .req_strobe(strobe_a), .req_ack(ack_a), .rddata(rddata_a),
      .vram_addr(vaddr_a), .vram_rden(rden_a), .vram_rddata(vdata_a)
   );

   vram_fetch_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LATENCY(3)) u_dut_b (
      .clk(clk), .rst(rst), .line_start(line_start), .sprites_enabled(spr_en),
      .req_addr(addr_b), .req_strobe(strobe_b), .req_ack(ack_b), .rddata(rddata_b),
      .vram_addr(vaddr_b), .vram_rden(rden_b), .vram_rddata(vdata_b)
   );

   function automatic logic [31:0] ram_word(input logic [15:0] a);
      return (a == 16'h1234) ? 32'hDEADBEEF : {16'hC0DE, a};
   endfunction

   // RAM models: data is valid only in the cycle rden+L, garbage otherwise.
   logic        va;
   logic [31:0] da;
   logic [2:0]  vb;
   logic [31:0] db [3];

   always @(posedge clk) begin
      va    <= rden_a;
      da    <= ram_word(vaddr_a);
      vb    <= {vb[1:0], rden_b};
      db[0] <= ram_word(vaddr_b);
      db[1] <= db[0];
      db[2] <= db[1];
   end

   assign vdata_a = va    ? da    : 32'hBAD0BAD0;
   assign vdata_b = vb[2] ? db[2] : 32'hBAD1BAD1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits for the next ack on instance A and checks requester, spacing and data.
   task automatic expect_ack(input string tag, input logic [2:0] exp, input int gap);
      int n = 0;
      int idx;
      do begin
         step();
         n++;
      end while (ack_a == 3'b000 && n < 40);
      idx = (exp == 3'b001) ? 0 : (exp == 3'b010) ? 1 : 2;
      chk({tag, "_ack"},  {61'd0, ack_a}, {61'd0, exp});
      chk({tag, "_gap"},  64'(n), 64'(gap));
      chk({tag, "_data"}, {32'd0, rddata_a}, {32'd0, ram_word(addr_a[idx*16 +: 16])});
   endtask

   initial begin
      int n;
      logic seen;

      rst = 1'b1; line_start = 1'b0; spr_en = 1'b1;
      addr_a = '0; strobe_a = '0; addr_b = '0; strobe_b = '0;
      va = 1'b0; vb = '0;
      step(); step();
      chk("reset_a", {ack_a, rden_a, vaddr_a, rddata_a}, 64'd0);
      chk("reset_b", {ack_b, rden_b, vaddr_b, rddata_b}, 64'd0);
      rst = 1'b0;
      step();

      // Single request, L=1
      addr_a = {16'h0000, 16'h0000, 16'h1234};
      strobe_a = 3'b001;
      chk("single_t0_rden", {63'd0, rden_a}, 64'd0);
      step();
      chk("single_t1", {ack_a, rden_a, vaddr_a}, {3'b000, 1'b1, 16'h1234});
      step();
      chk("single_t2", {ack_a, rden_a}, {3'b000, 1'b0});
      step();
      chk("single_t3_ack", {61'd0, ack_a}, 64'd1);
      chk("single_t3_data", {32'd0, rddata_a}, {32'd0, 32'hDEADBEEF});
      strobe_a = 3'b000;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack_a != 3'b000 || rden_a) seen = 1'b1;
      end
      chk("single_quiet", {63'd0, seen}, 64'd0);
      chk("single_hold", {32'd0, rddata_a}, {32'd0, 32'hDEADBEEF});

      // Contention
      line_start = 1'b1; step(); line_start = 1'b0;
      addr_a = {16'h0300, 16'h0200, 16'h0100};
      strobe_a = 3'b111;
`ifdef ARB_ROUND_ROBIN_EN
      expect_ack("rr_a", 3'b001, 3);
      expect_ack("rr_b", 3'b010, 3);
      expect_ack("rr_c", 3'b100, 3);
      expect_ack("rr_d", 3'b001, 3);
      expect_ack("rr_e", 3'b010, 3);
      expect_ack("rr_f", 3'b100, 3);
      strobe_a = 3'b000;
`else
      expect_ack("fix_a", 3'b001, 3);
      strobe_a[0] = 1'b0;
      expect_ack("fix_b", 3'b010, 3);
      strobe_a[1] = 1'b0;
      expect_ack("fix_c", 3'b100, 3);
      strobe_a[2] = 1'b0;
`endif
      step(); step(); step();

      // Sprite gating
      spr_en = 1'b0;
      addr_a = {16'h0ABC, 16'h0000, 16'h0000};
      strobe_a = 3'b100;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack_a != 3'b000 || rden_a) seen = 1'b1;
      end
      chk("spr_gated", {63'd0, seen}, 64'd0);
      spr_en = 1'b1;
      expect_ack("spr_en", 3'b100, 3);
      strobe_a = 3'b000;
      step(); step();

      // Latency 3 on instance B
      addr_b = {16'h0000, 16'h0042, 16'h0000};
      strobe_b = 3'b010;
      step();
      chk("lat3_rden", {rden_b, vaddr_b}, {1'b1, 16'h0042});
      n = 1;
      while (ack_b == 3'b000 && n < 40) begin
         step();
         n++;
      end
      chk("lat3_gap", 64'(n), 64'd5);
      chk("lat3_ack", {61'd0, ack_b}, 64'd2);
      chk("lat3_data", {32'd0, rddata_b}, {32'd0, 32'hC0DE0042});
      strobe_b = 3'b000;
      step(); step();

      // line_start restores search start to requester 0
      addr_a = {16'h0030, 16'h0020, 16'h0010};
      strobe_a = 3'b010;
      expect_ack("ls_l1", 3'b010, 3);
      strobe_a = 3'b000;
      step();
      line_start = 1'b1; step(); line_start = 1'b0;
      strobe_a = 3'b101;
      expect_ack("ls_first", 3'b001, 3);
      strobe_a[0] = 1'b0;
      expect_ack("ls_second", 3'b100, 3);
      strobe_a = 3'b000;
      step(); step();

      // Reset during WAIT
      addr_a = {16'h0000, 16'h0000, 16'h0777};
      strobe_a = 3'b001;
      step();
      step();
      strobe_a = 3'b000;
      rst = 1'b1;
      #1;
      chk("rst_async", {ack_a, rden_a, vaddr_a, rddata_a}, 64'd0);
      step();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack_a != 3'b000 || rden_a) seen = 1'b1;
      end
      chk("rst_no_ack", {63'd0, seen}, 64'd0);
      chk("rst_data_ignored", {32'd0, rddata_a}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
